// File: rtl/pc_fetch_sequencer.sv
// Program counter and instruction fetch stage: fetches one word per step over a
// req/ready handshake, presents it to the core for one cycle, then picks the next PC.
module pc_fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic [15:0] jump_addr,
  input  logic [15:0] stack_top,
  output logic [15:0] pc,
  output logic [15:0] retired,
  output logic        halted
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  localparam logic [1:0] OP_CALL = 2'b01;
  localparam logic [1:0] OP_RET  = 2'b11;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] retired_q, retired_d;
  logic        halted_q, halted_d;
  logic        mem_req_q, mem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic [1:0]  op;

  assign op = instr_q[15:14];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    halted_d  = halted_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          instr_d = mem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        retired_d = retired_q + 16'd1;
        case (op)
          OP_CALL: pc_d = jump_addr;
          OP_RET:  pc_d = stack_top;
          default: begin
            // Sequential step off the top of the address space halts instead of wrapping.
            if (pc_q == 16'hFFFF) halted_d = 1'b1;
            else                  pc_d     = pc_q + 16'd1;
          end
        endcase
        if (halted_d)  state_d = S_HALT;
        else if (stop) state_d = S_IDLE;
        else           state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state, so mem_ready never reaches mem_req combinationally.
  assign mem_req_d     = (state_d == S_FETCH);
  assign instr_valid_d = (state_d == S_EXEC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 16'h0000;
      retired_q     <= 16'h0000;
      halted_q      <= 1'b0;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      retired_q     <= retired_d;
      halted_q      <= halted_d;
      mem_req_q     <= mem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign retired     = retired_q;
  assign halted      = halted_q;

endmodule
